// File: rtl/riscv_pkg.sv
// Shared datapath definitions: base integer width and register-file init states.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } regfile_state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bus: one write port, NUM_RD_PORTS packed read ports, init status.
interface regfile_mp_if #(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                                   RegWrite;
    logic [AW-1:0]                          rd;
    logic [XLEN-1:0]                        WriteData;
    logic [NUM_RD_PORTS-1:0][AW-1:0]        rs;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]      rdata;
    logic                                   init_busy;

    modport master (
        output RegWrite, rd, WriteData, rs,
        input  rdata, init_busy
    );

    modport slave (
        input  RegWrite, rd, WriteData, rs,
        output rdata, init_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired x0, optional write bypass and
// a post-reset clearing walk that zeroes x1..x(NUM_REGS-1), one per cycle.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] register_memory [NUM_REGS];

    regfile_state_t r_state;
    regfile_state_t w_state_nxt;
    logic [AW-1:0]  r_ptr;
    logic           w_ptr_last;
    logic           w_wr_en;

    assign w_ptr_last = (r_ptr == AW'(NUM_REGS - 1));

    // Writes to x0 or to addresses beyond NUM_REGS are dropped silently.
    assign w_wr_en = (r_state == RF_READY) && bus.RegWrite &&
                     (bus.rd != '0) && (int'(bus.rd) < NUM_REGS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RF_CLEAR: if (w_ptr_last) w_state_nxt = RF_READY;
            RF_READY: w_state_nxt = RF_READY;
            default:  w_state_nxt = RF_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_ptr   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RF_CLEAR) begin
                register_memory[r_ptr] <= '0;
                // Pointer parks on the last register rather than wrapping.
                if (!w_ptr_last) r_ptr <= r_ptr + AW'(1);
            end else if (w_wr_en) begin
                register_memory[bus.rd] <= bus.WriteData;
            end
        end
    end

    assign bus.init_busy = (r_state == RF_CLEAR);

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
        logic [XLEN-1:0] w_port;
        logic            w_addr_ok;

        assign w_addr_ok = (bus.rs[g] != '0) && (int'(bus.rs[g]) < NUM_REGS);

        always_comb begin
            w_port = '0;
            if (r_state == RF_READY && w_addr_ok) begin
                if (BYPASS != 0 && bus.RegWrite && bus.rd == bus.rs[g])
                    w_port = bus.WriteData;
                else
                    w_port = register_memory[bus.rs[g]];
            end
        end

        assign bus.rdata[g] = w_port;
    end
endmodule
